// File: rtl/npc_fetch_ctrl_if.sv
//==============================================================================
// npc_fetch_ctrl_if : D-stage control/operand bus and fetch-side outputs
// Rev 1.0
//==============================================================================
`default_nettype none

interface npc_fetch_ctrl_if;
  logic        StallD;
  logic        ImemReady;
  logic [2:0]  NPCSelect;
  logic [2:0]  CmpMode;
  logic        LinkReqD;
  logic [31:0] RsDataD;
  logic [31:0] RtDataD;
  logic [15:0] Imm16D;
  logic [25:0] Index26D;
  logic        FetchReq;
  logic [31:0] PCF;
  logic [31:0] PCD;
  logic        ValidD;
  logic        Taken;
  logic        LinkEn;
  logic [31:0] LinkAddr;

  modport master (
    output StallD, ImemReady, NPCSelect, CmpMode, LinkReqD,
           RsDataD, RtDataD, Imm16D, Index26D,
    input  FetchReq, PCF, PCD, ValidD, Taken, LinkEn, LinkAddr
  );

  modport slave (
    input  StallD, ImemReady, NPCSelect, CmpMode, LinkReqD,
           RsDataD, RtDataD, Imm16D, Index26D,
    output FetchReq, PCF, PCD, ValidD, Taken, LinkEn, LinkAddr
  );
endinterface

`default_nettype wire

// File: rtl/npc_fetch_ctrl.sv
//==============================================================================
// npc_fetch_ctrl : fetch PC, F/D pipeline bits, branch resolve, next-PC select
// Rev 1.0
//==============================================================================
`default_nettype none

module npc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset_n,
  npc_fetch_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pcd_q, pcd_d;
  logic        valid_q, valid_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] pcd_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic        cond;
  logic        is_br, is_j, is_jr, is_bgeal;
  logic        taken;
  logic        d_adv;
  logic        f_adv;

  assign pcd_plus4 = pcd_q + 32'd4;
  assign br_target = pcd_plus4 + {{14{bus.Imm16D[15]}}, bus.Imm16D, 2'b00};
  assign j_target  = {pcd_plus4[31:28], bus.Index26D, 2'b00};

  always_comb begin
    cond = 1'b0;
    case (bus.CmpMode)
      3'b001:  cond = (bus.RsDataD == bus.RtDataD);
      3'b010:  cond = (bus.RsDataD != bus.RtDataD);
      3'b011:  cond = ($signed(bus.RsDataD) >  32'sd0);
      3'b100:  cond = ($signed(bus.RsDataD) >= 32'sd0);
      3'b101:  cond = ($signed(bus.RsDataD) <  32'sd0);
      3'b110:  cond = ($signed(bus.RsDataD) <= 32'sd0);
      3'b111:  cond = ($signed(bus.RsDataD) >= $signed(bus.RtDataD));
      default: cond = 1'b0;
    endcase
  end

  // Encodings 101-111 fall through as sequential.
  always_comb begin
    is_br    = 1'b0;
    is_j     = 1'b0;
    is_jr    = 1'b0;
    is_bgeal = 1'b0;
    target   = br_target;
    case (bus.NPCSelect)
      3'b001:  is_br = 1'b1;
      3'b010:  begin is_j  = 1'b1; target = j_target;     end
      3'b011:  begin is_jr = 1'b1; target = bus.RsDataD;  end
      3'b100:  is_bgeal = 1'b1;
      default: ;
    endcase
  end

  assign taken = valid_q & (((is_br | is_bgeal) & cond) | is_j | is_jr);
  assign d_adv = ~bus.StallD;
  assign f_adv = ~bus.StallD & bus.ImemReady;

  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    pcd_d   = pcd_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    case (state_q)
      ST_RUN: begin
        if (f_adv) begin
          pcd_d   = pcf_q;
          valid_d = 1'b1;
          pcf_d   = taken ? target : (pcf_q + 32'd4);
        end else if (d_adv) begin
          // D consumed but IMem still busy: park the redirect until the delay slot lands.
          valid_d = 1'b0;
          if (taken) begin
            pend_d  = target;
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (f_adv) begin
          pcd_d   = pcf_q;
          valid_d = 1'b1;
          pcf_d   = pend_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pcf_q   <= RESET_PC;
      pcd_q   <= 32'd0;
      valid_q <= 1'b0;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      pcd_q   <= pcd_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.FetchReq = reset_n;
  assign bus.PCF      = pcf_q;
  assign bus.PCD      = pcd_q;
  assign bus.ValidD   = valid_q;
  assign bus.Taken    = taken;
  assign bus.LinkEn   = valid_q & ~bus.StallD & bus.LinkReqD & (~is_bgeal | cond);
  assign bus.LinkAddr = pcd_q + 32'd8;

endmodule

`default_nettype wire
